// File: rtl/vis_block_fetch_if.sv
// vis_block_fetch_if
//   Wishbone-like read bus between the visibility fetch master and the
//   correlator blocks' read-back slave.
//
//   Signals (named from the master's point of view):
//     cyc_o  bus cycle active
//     stb_o  read strobe, one word per cycle
//     we_o   write enable (always 0, the master only reads)
//     bst_o  high while further strobes will follow in this fetch
//     adr_o  slave address {block, slot, word}
//     ack_i  slave acknowledge; dat_i is valid in the same cycle
//     dat_i  read data
//
//   Modports: master (fetch engine), slave (correlator read-back port).
interface vis_block_fetch_if #(
  parameter int ABITS = 8,
  parameter int ACCUM = 24
) ();
  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic             bst_o;
  logic [ABITS-1:0] adr_o;
  logic             ack_i;
  logic [ACCUM-1:0] dat_i;

  modport master (
    output cyc_o, stb_o, we_o, bst_o, adr_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, bst_o, adr_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/vis_block_fetch.sv
// vis_block_fetch
//   Reads one complete visibility bank back from a correlator block over a
//   pipelined Wishbone-like bus and streams every returned word into a
//   linear host-side buffer.
//
//   Every valid {block, slot, word} address is strobed exactly once, one
//   per cycle; slot codes TRATE..2^TBITS-1 are skipped. Acks are counted
//   independently of strobes, so any slave latency is tolerated. Each
//   accepted ack is written one cycle later to badr_o = ack index.
//   A fetch is aborted if TOUT consecutive cycles pass without an ack.
//
//   Ports:
//     clk_i     bus clock
//     rst       synchronous active-high reset
//     start_i   one-cycle request to fetch the inactive bank
//     busy_o    fetch in progress (also high in the done_o cycle)
//     done_o    one-cycle pulse after the final word is written
//     err_o     one-cycle pulse on timeout abort
//     missed_o  sticky: start_i arrived while busy
//     bus       read bus (master modport)
//     bwe_o     host-buffer write enable
//     badr_o    host-buffer address
//     bdat_o    host-buffer write data
module vis_block_fetch #(
  parameter int ACCUM = 24,
  parameter int TRATE = 12,
  parameter int TBITS = 4,
  parameter int BBITS = 1,
  parameter int ABITS = 3 + TBITS + BBITS,
  parameter int COUNT = 8 * TRATE * (1 << BBITS),
  parameter int CBITS = 8,
  parameter int TOUT  = 15,
  // Register delay used by older simulation models; no effect here.
  parameter int DELAY = 3
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 missed_o,
  vis_block_fetch_if.master    bus,
  output logic                 bwe_o,
  output logic [CBITS-1:0]     badr_o,
  output logic [ACCUM-1:0]     bdat_o
);

  // One extra bit so the counters can hold COUNT itself even when
  // COUNT == 2^CBITS.
  localparam int NW = CBITS + 1;
  localparam int TW = (TOUT < 2) ? 1 : $clog2(TOUT + 1);

  localparam logic [NW-1:0]    COUNT_C   = NW'(COUNT);
  localparam logic [NW-1:0]    LAST_C    = NW'(COUNT - 1);
  localparam logic [TW-1:0]    TOUT_LAST = TW'(TOUT - 1);
  localparam logic [TBITS-1:0] SLOT_LAST = TBITS'(TRATE - 1);

  if (COUNT > (1 << CBITS) || ABITS != 3 + TBITS + BBITS || DELAY < 0) begin : g_param_check
    $error("vis_block_fetch: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  state_t             state_reg,   state_next;
  logic [2:0]         word_reg,    word_next;
  logic [TBITS-1:0]   slot_reg,    slot_next;
  logic [BBITS-1:0]   blk_reg,     blk_next;
  logic [NW-1:0]      stb_cnt_reg, stb_cnt_next;   // strobes already issued
  logic [NW-1:0]      ack_cnt_reg, ack_cnt_next;   // acks accepted
  logic [TW-1:0]      tout_reg,    tout_next;
  logic               cyc_reg,     cyc_next;
  logic               stb_reg,     stb_next;
  logic               busy_reg,    busy_next;
  logic               done_reg,    done_next;
  logic               err_reg,     err_next;
  logic               missed_reg,  missed_next;
  logic               bwe_reg,     bwe_next;
  logic [CBITS-1:0]   badr_reg,    badr_next;
  logic [ACCUM-1:0]   bdat_reg,    bdat_next;
  logic               ack_take;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      word_reg    <= '0;
      slot_reg    <= '0;
      blk_reg     <= '0;
      stb_cnt_reg <= '0;
      ack_cnt_reg <= '0;
      tout_reg    <= '0;
      cyc_reg     <= 1'b0;
      stb_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      missed_reg  <= 1'b0;
      bwe_reg     <= 1'b0;
      badr_reg    <= '0;
      bdat_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      slot_reg    <= slot_next;
      blk_reg     <= blk_next;
      stb_cnt_reg <= stb_cnt_next;
      ack_cnt_reg <= ack_cnt_next;
      tout_reg    <= tout_next;
      cyc_reg     <= cyc_next;
      stb_reg     <= stb_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      missed_reg  <= missed_next;
      bwe_reg     <= bwe_next;
      badr_reg    <= badr_next;
      bdat_reg    <= bdat_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    word_next    = word_reg;
    slot_next    = slot_reg;
    blk_next     = blk_reg;
    stb_cnt_next = stb_cnt_reg;
    ack_cnt_next = ack_cnt_reg;
    tout_next    = tout_reg;
    cyc_next     = cyc_reg;
    stb_next     = stb_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    missed_next  = missed_reg;
    bwe_next     = 1'b0;
    badr_next    = badr_reg;
    bdat_next    = bdat_reg;
    ack_take     = 1'b0;

    // busy_reg also covers the done_o cycle, so a start there is missed.
    if (start_i && busy_reg) begin
      missed_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start_i && !busy_reg) begin
          state_next   = ST_READ;
          cyc_next     = 1'b1;
          stb_next     = 1'b1;
          word_next    = '0;
          slot_next    = '0;
          blk_next     = '0;
          stb_cnt_next = '0;
          ack_cnt_next = '0;
          tout_next    = '0;
          missed_next  = 1'b0;
        end
      end

      ST_READ, ST_DRAIN: begin
        // Acks beyond the bank size are dropped but still count as
        // bus activity for the timeout.
        ack_take = bus.ack_i && (ack_cnt_reg != COUNT_C);
        if (ack_take) begin
          ack_cnt_next = ack_cnt_reg + NW'(1);
          bwe_next     = 1'b1;
          badr_next    = ack_cnt_reg[CBITS-1:0];
          bdat_next    = bus.dat_i;
        end
        tout_next = bus.ack_i ? '0 : tout_reg + TW'(1);

        if (state_reg == ST_READ) begin
          if (stb_cnt_reg == LAST_C) begin
            stb_next   = 1'b0;
            state_next = ST_DRAIN;
            word_next  = '0;
            slot_next  = '0;
            blk_next   = '0;
          end else begin
            stb_cnt_next = stb_cnt_reg + NW'(1);
            if (word_reg == 3'd7) begin
              word_next = '0;
              if (slot_reg == SLOT_LAST) begin
                slot_next = '0;
                blk_next  = blk_reg + BBITS'(1);
              end else begin
                slot_next = slot_reg + TBITS'(1);
              end
            end else begin
              word_next = word_reg + 3'd1;
            end
          end
        end

        if (state_reg == ST_DRAIN && ack_cnt_reg == COUNT_C) begin
          state_next = ST_IDLE;
          cyc_next   = 1'b0;
          done_next  = 1'b1;
        end else if (!bus.ack_i && tout_reg == TOUT_LAST) begin
          // TOUT ack-less cycles: abandon the fetch, keep partial writes.
          state_next = ST_IDLE;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          err_next   = 1'b1;
          word_next  = '0;
          slot_next  = '0;
          blk_next   = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE) || done_next;
  end

  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign err_o     = err_reg;
  assign missed_o  = missed_reg;
  assign bus.cyc_o = cyc_reg;
  assign bus.stb_o = stb_reg;
  assign bus.we_o  = 1'b0;
  assign bus.bst_o = stb_reg && (stb_cnt_reg != LAST_C);
  assign bus.adr_o = {blk_reg, slot_reg, word_reg};
  assign bwe_o     = bwe_reg;
  assign badr_o    = badr_reg;
  assign bdat_o    = bdat_reg;

endmodule
